// File: rtl/multicrack_ctrl_if.sv
// Core-side bus between multicrack_ctrl and its array of crack cores.
// The controller uses the master modport; a core model uses the slave modport.
interface multicrack_ctrl_if #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24
);
  logic [NUM_CORES-1:0]       core_rdy;
  logic [NUM_CORES-1:0]       core_key_valid;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_en;
  logic [NUM_CORES-1:0]       core_abort;
  logic [NUM_CORES*KEY_W-1:0] core_base;

  modport master (
    input  core_rdy, core_key_valid, core_key,
    output core_en, core_abort, core_base
  );

  modport slave (
    output core_rdy, core_key_valid, core_key,
    input  core_en, core_abort, core_base
  );
endinterface

// File: rtl/multicrack_ctrl.sv
// Launches a partitioned key search over NUM_CORES crack cores, picks the
// lowest-index core that reports a key, aborts the rest, and reports the result.
module multicrack_ctrl #(
  parameter int          NUM_CORES  = 2,
  parameter int          KEY_W      = 24,
  parameter logic [31:0] MAX_CYCLES = 32'hFFFF_FFFF,
  parameter int          SETTLE     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  multicrack_ctrl_if.master    core_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 timeout,
  output logic [KEY_W-1:0]     key,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] winner,
  output logic [31:0]          cycles
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int SHIFT = KEY_W - $clog2(NUM_CORES);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_LAUNCH, S_SETTLE, S_RUN, S_ABORT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] fin_q, fin_d;
  logic [NUM_CORES-1:0] en_q, en_d;
  logic [NUM_CORES-1:0] abort_q, abort_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;
  logic                 timeout_q, timeout_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [31:0]          cycles_q, cycles_d;

  logic [32:0]              cyc_sum;
  logic [31:0]              cyc_inc;
  logic [NUM_CORES-1:0]     hit;
  logic [NUM_CORES-1:0]     fin_now;
  logic [IDX_W-1:0]         win_idx;
  logic [KEY_W-1:0]         win_key;
  logic [NUM_CORES*KEY_W-1:0] base;

  // Each core searches an equal slice of the key space starting at its base.
  always_comb begin
    base = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      base[i*KEY_W +: KEY_W] = KEY_W'(i) << SHIFT;
    end
  end

  always_comb begin
    cyc_sum = {1'b0, cycles_q} + 33'd1;
    cyc_inc = cyc_sum[32] ? '1 : cyc_sum[31:0];
    hit     = core_bus.core_rdy & core_bus.core_key_valid;
    fin_now = fin_q | core_bus.core_rdy;
    win_idx = '0;
    win_key = '0;
    // Descending scan so the lowest reporting index wins ties.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_idx = IDX_W'(i);
        win_key = core_bus.core_key[i*KEY_W +: KEY_W];
      end
    end

    state_d   = state_q;
    fin_d     = fin_q;
    en_d      = '0;
    abort_d   = '0;
    settle_d  = settle_q;
    found_d   = found_q;
    timeout_d = timeout_q;
    key_d     = key_q;
    winner_d  = winner_q;
    cycles_d  = cycles_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_WAIT_RDY;
          found_d   = 1'b0;
          timeout_d = 1'b0;
          key_d     = '0;
          winner_d  = '0;
          cycles_d  = '0;
        end
      end
      S_WAIT_RDY: begin
        if (&core_bus.core_rdy) begin
          state_d  = S_LAUNCH;
          en_d     = '1;
          cycles_d = 32'd1;
          fin_d    = '0;
          settle_d = '0;
        end
      end
      S_LAUNCH: begin
        state_d = (SETTLE == 0) ? S_RUN : S_SETTLE;
      end
      S_SETTLE: begin
        cycles_d = cyc_inc;
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_RUN: begin
        cycles_d = cyc_inc;
        fin_d    = fin_now;
        // A reported key outranks both completion and timeout in the same cycle.
        if (|hit) begin
          found_d  = 1'b1;
          key_d    = win_key;
          winner_d = win_idx;
          abort_d  = ~fin_now;
          state_d  = S_ABORT;
        end else if (&fin_now) begin
          state_d = S_DONE;
        end else if (cyc_inc >= MAX_CYCLES) begin
          timeout_d = 1'b1;
          abort_d   = ~fin_now;
          state_d   = S_ABORT;
        end
      end
      S_ABORT: begin
        cycles_d = cyc_inc;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fin_q     <= '0;
      en_q      <= '0;
      abort_q   <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
      key_q     <= '0;
      winner_q  <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      fin_q     <= fin_d;
      en_q      <= en_d;
      abort_q   <= abort_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      timeout_q <= timeout_d;
      key_q     <= key_d;
      winner_q  <= winner_d;
      cycles_q  <= cycles_d;
    end
  end

  assign core_bus.core_en    = en_q;
  assign core_bus.core_abort = abort_q;
  assign core_bus.core_base  = base;
  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign timeout = timeout_q;
  assign key     = key_q;
  assign winner  = winner_q;
  assign cycles  = cycles_q;
endmodule

// File: tb/tb_multicrack_ctrl.sv
// Bench for multicrack_ctrl: scenario-level outcome model (per-core finish
// times) against a 4-core DUT with a short timeout, plus a default 2-core DUT.
module tb_multicrack_ctrl;
  localparam int NC    = 4;
  localparam int KW    = 24;
  localparam int MAXC  = 100;
  localparam int ST    = 2;
  localparam int RUN_N = 1 + ST;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, found, timeout;
  logic [KW-1:0] key;
  logic [1:0]    winner;
  logic [31:0]   cycles;

  logic start2 = 1'b0;
  logic busy2, done2, found2, timeout2;
  logic [23:0] key2;
  logic [0:0]  winner2;
  logic [31:0] cycles2;

  multicrack_ctrl_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();
  multicrack_ctrl_if #(.NUM_CORES(2), .KEY_W(24)) bus2 ();

  multicrack_ctrl #(.NUM_CORES(NC), .KEY_W(KW), .MAX_CYCLES(32'd100), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .core_bus(bus),
    .busy(busy), .done(done), .found(found), .timeout(timeout),
    .key(key), .winner(winner), .cycles(cycles)
  );

  multicrack_ctrl #(.NUM_CORES(2), .KEY_W(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .core_bus(bus2),
    .busy(busy2), .done(done2), .found(found2), .timeout(timeout2),
    .key(key2), .winner(winner2), .cycles(cycles2)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  // Scenario description: cycle index (launch cycle = 0) at which each core
  // raises rdy, whether it then reports a key, and which key.
  int          finT[NC];
  bit          valC[NC];
  logic [KW-1:0] keyC[NC];
  int          rdy0Delay;
  int          startInjN;
  int          rstAtN;

  bit            expFound, expTimeout;
  logic [KW-1:0] expKey;
  logic [1:0]    expWinner;
  logic [NC-1:0] expAbort;
  int            expDecN, expDoneN;
  logic [31:0]   expCycles;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setDefaults();
    for (int i = 0; i < NC; i++) begin
      finT[i] = NEVER;
      valC[i] = 1'b0;
      keyC[i] = '0;
    end
    rdy0Delay = 0;
    startInjN = -1;
    rstAtN = -1;
  endtask

  // Outcome of a search from the scenario alone. Cores are only observed from
  // the first RUN cycle; the counter shows the cycle index after the launch
  // cycle, and the timeout fires on the cycle whose successor would reach MAXC.
  task automatic computeExpected();
    int e[NC];
    int nv, allN, toN;
    nv = NEVER;
    allN = 0;
    toN = (MAXC - 1 > RUN_N) ? MAXC - 1 : RUN_N;
    for (int i = 0; i < NC; i++) begin
      e[i] = (finT[i] < RUN_N) ? RUN_N : finT[i];
      if (valC[i] && e[i] < nv) nv = e[i];
      if (e[i] > allN) allN = e[i];
    end
    expFound = 1'b0;
    expTimeout = 1'b0;
    expKey = '0;
    expWinner = '0;
    expAbort = '0;
    if (nv <= toN) begin
      expFound = 1'b1;
      expDecN = nv;
      for (int i = NC - 1; i >= 0; i--) begin
        if (valC[i] && e[i] == nv) begin
          expWinner = 2'(i);
          expKey = keyC[i];
        end
      end
      for (int i = 0; i < NC; i++) expAbort[i] = (e[i] > nv);
      expDoneN = nv + 2;
    end else if (allN <= toN) begin
      expDecN = allN;
      expDoneN = allN + 1;
    end else begin
      expTimeout = 1'b1;
      expDecN = toN;
      for (int i = 0; i < NC; i++) expAbort[i] = (e[i] > toN);
      expDoneN = toN + 2;
    end
    expCycles = 32'(expDoneN);
  endtask

  task automatic applyStimulus(input string name);
    int c, n, enC, enCnt, abCnt, abN, doneN;
    logic [NC-1:0] abMask;
    bit launched, finished, overlap, didReset;
    int abortAt[NC];
    computeExpected();
    c = 0; n = 0; enC = -1; enCnt = 0; abCnt = 0; abN = -1; doneN = -1;
    abMask = '0; launched = 0; finished = 0; overlap = 0; didReset = 0;
    for (int i = 0; i < NC; i++) abortAt[i] = NEVER;
    @(negedge clk);
    start = 1'b1;
    bus.core_key_valid = '0;
    bus.core_rdy = '1;
    bus.core_rdy[0] = (0 > rdy0Delay);
    for (int k = 0; k < 400 && !finished && !didReset; k++) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (c == 1) checkOutput({name, ":busy_after_start"}, {62'd0, busy, done}, 64'd2);
      if (launched) n++;
      if (bus.core_en != '0) begin
        enCnt++;
        if (!launched) begin
          launched = 1;
          n = 0;
          enC = c;
          checkOutput({name, ":en_mask"}, bus.core_en, {NC{1'b1}});
        end
      end
      if (bus.core_abort != '0) begin
        abCnt++;
        abN = n;
        abMask |= bus.core_abort;
        for (int i = 0; i < NC; i++) if (bus.core_abort[i]) abortAt[i] = n;
      end
      if (bus.core_en != '0 && bus.core_abort != '0) overlap = 1;
      if (done) begin
        finished = 1;
        doneN = n;
      end else if (launched && n == rstAtN) begin
        checkOutput({name, ":busy_before_rst"}, busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput({name, ":rst_status"}, {busy, done, found, timeout, bus.core_en, bus.core_abort}, 0);
        checkOutput({name, ":rst_data"}, {key, winner, cycles}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.core_rdy = '1;
        bus.core_key_valid = '0;
        didReset = 1;
      end else if (!launched) begin
        bus.core_rdy = '1;
        bus.core_rdy[0] = (c > rdy0Delay);
        bus.core_key_valid = '0;
      end else begin
        for (int i = 0; i < NC; i++) begin
          bus.core_key[i*KW +: KW] = keyC[i];
          if (n > abortAt[i] || n == 0) begin
            bus.core_rdy[i] = 1'b1;
            bus.core_key_valid[i] = 1'b0;
          end else if (n >= finT[i]) begin
            bus.core_rdy[i] = 1'b1;
            bus.core_key_valid[i] = valC[i];
          end else begin
            bus.core_rdy[i] = 1'b0;
            bus.core_key_valid[i] = 1'b0;
          end
        end
        if (n == startInjN) start = 1'b1;
      end
    end
    if (didReset) return;
    checkOutput({name, ":finished"}, finished, 1);
    checkOutput({name, ":en_latency"}, enC, rdy0Delay + 2);
    checkOutput({name, ":en_pulses"}, enCnt, 1);
    checkOutput({name, ":en_abort_overlap"}, overlap, 0);
    checkOutput({name, ":done_cycle"}, doneN, expDoneN);
    checkOutput({name, ":found"}, found, expFound);
    checkOutput({name, ":timeout"}, timeout, expTimeout);
    checkOutput({name, ":key"}, key, expKey);
    checkOutput({name, ":winner"}, winner, expWinner);
    checkOutput({name, ":cycles"}, cycles, expCycles);
    checkOutput({name, ":abort_pulses"}, abCnt, (expAbort != '0) ? 1 : 0);
    checkOutput({name, ":abort_mask"}, abMask, expAbort);
    if (expAbort != '0) checkOutput({name, ":abort_when"}, abN, expDecN + 1);
    bus.core_rdy = '1;
    bus.core_key_valid = '0;
    repeat (3) @(negedge clk);
    checkOutput({name, ":hold"}, {busy, done, found, timeout, key, winner, cycles},
                {1'b0, 1'b1, expFound, expTimeout, expKey, expWinner, expCycles});
  endtask

  initial begin
    logic [47:0] expBase;
    setDefaults();
    bus.core_rdy = '1;
    bus.core_key_valid = '0;
    bus.core_key = '0;
    bus2.core_rdy = '1;
    bus2.core_key_valid = '0;
    bus2.core_key = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_status", {busy, done, found, timeout, bus.core_en, bus.core_abort}, 0);
    checkOutput("reset_data", {key, winner, cycles}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_after_release", {busy, done, bus.core_en}, 0);

    expBase = '0;
    for (int i = 0; i < 2; i++) expBase[i*24 +: 24] = 24'(i) << 23;
    checkOutput("base_2core", bus2.core_base, expBase);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("en2_edge1", bus2.core_en, 2'b00);
    @(negedge clk);
    checkOutput("en2_edge2", bus2.core_en, 2'b11);
    @(negedge clk);
    checkOutput("en2_edge3", bus2.core_en, 2'b00);
    repeat (4) @(negedge clk);
    checkOutput("done2_all_rdy", {done2, found2, timeout2, bus2.core_abort}, 5'b10000);

    setDefaults();
    finT[2] = 50; valC[2] = 1'b1; keyC[2] = 24'h00A5F3;
    applyStimulus("core2_wins");
    checkOutput("core2_wins:spec_key", {found, key, winner}, {1'b1, 24'h00A5F3, 2'd2});

    setDefaults();
    finT[1] = 20; valC[1] = 1'b1; keyC[1] = 24'h111111;
    finT[3] = 20; valC[3] = 1'b1; keyC[3] = 24'h333333;
    startInjN = 10;
    applyStimulus("tie_1_3");

    setDefaults();
    finT[0] = 5; finT[1] = 30; finT[2] = 12; finT[3] = 45;
    startInjN = 20;
    applyStimulus("all_fail");

    setDefaults();
    rdy0Delay = 5;
    applyStimulus("timeout_wait_rdy");

    setDefaults();
    finT[3] = 99; valC[3] = 1'b1; keyC[3] = 24'hC0FFEE;
    applyStimulus("key_at_timeout");

    setDefaults();
    rstAtN = 40;
    applyStimulus("reset_in_run");

    setDefaults();
    finT[0] = 7; valC[0] = 1'b1; keyC[0] = 24'h0BEEF0;
    finT[1] = 3;
    applyStimulus("after_reset");

    for (int r = 0; r < 8; r++) begin
      setDefaults();
      for (int i = 0; i < NC; i++) begin
        finT[i] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, 130));
        valC[i] = ($urandom_range(0, 2) == 0);
        keyC[i] = 24'($urandom);
      end
      rdy0Delay = int'($urandom_range(0, 3));
      applyStimulus($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end
endmodule

// File: doc/multicrack_ctrl.md
MULTICRACK_CTRL -- requirements
Module: multicrack_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 2, number of attached crack cores; SHALL be a power of two, 1..8.
REQ-002 Parameter KEY_W, default 24, key width in bits.
REQ-003 Parameter MAX_CYCLES, default 32'hFFFF_FFFF, search timeout in clk cycles counted from launch.
REQ-004 Parameter SETTLE, default 2, cycles after launch during which core_rdy is ignored.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request a new search; sampled in IDLE and DONE only.
REQ-008 core_rdy  in  NUM_CORES  per-core ready; high = idle or finished.
REQ-009 core_key_valid  in  NUM_CORES  per-core result-valid flag, meaningful when core_rdy is high.
REQ-010 core_key  in  NUM_CORES*KEY_W  per-core found key; core i occupies bits [i*KEY_W +: KEY_W].
REQ-011 core_en  out  NUM_CORES  one-cycle launch pulse per core.
REQ-012 core_abort  out  NUM_CORES  one-cycle abort pulse per core.
REQ-013 core_base  out  NUM_CORES*KEY_W  partition start for core i = i << (KEY_W - log2(NUM_CORES)); constant.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  high in DONE only.
REQ-016 found  out  1  a core reported a valid key in the last search.
REQ-017 timeout  out  1  the last search ended by MAX_CYCLES.
REQ-018 key  out  KEY_W  winning key; 0 when found=0.
REQ-019 winner  out  max(1,log2(NUM_CORES))  index of the winning core.
REQ-020 cycles  out  32  launch-to-DONE cycle count of the last search.

Function
REQ-021 States SHALL be IDLE, WAIT_RDY, LAUNCH, SETTLE, RUN, ABORT, DONE.
REQ-022 IDLE/DONE: start=1 -> WAIT_RDY; found, timeout, key, winner, cycles cleared on that edge; done falls.
REQ-023 WAIT_RDY: remain until all core_rdy bits high, then -> LAUNCH.
REQ-024 LAUNCH: core_en = all ones for exactly this one cycle; cycles reset to 1; -> SETTLE.
REQ-025 SETTLE: core_rdy ignored for SETTLE cycles (counter), then -> RUN.
REQ-026 RUN: core i is finished when core_rdy[i]=1; the finished-mask SHALL be sticky for the search.
REQ-027 RUN: if any core has core_rdy[i]&core_key_valid[i] this cycle, lowest such index wins; key, winner latched, found=1, -> ABORT.
REQ-028 RUN: if every core is finished with no valid key, found=0 -> DONE directly, no abort pulse.
REQ-029 RUN: cycles reaching MAX_CYCLES with no winner -> timeout=1 -> ABORT; valid key in the same cycle takes priority over timeout.
REQ-030 ABORT: core_abort pulsed one cycle to every core not yet finished (winner excluded); -> DONE.
REQ-031 cycles SHALL increment once per cycle in SETTLE, RUN and ABORT, saturating at all ones; frozen in DONE.
REQ-032 core_en and core_abort SHALL never be high in the same cycle, nor outside LAUNCH/ABORT respectively.
REQ-033 start while busy SHALL be ignored.
REQ-034 key/winner/found/timeout/cycles SHALL hold stable throughout DONE.

Reset
REQ-035 rst_n low SHALL immediately force IDLE and all outputs to 0, including mid-search; core_en and core_abort go low asynchronously.
REQ-036 After reset release the block SHALL take no action until start.

Verification
REQ-037 NUM_CORES=2, both rdy high, start pulse -> core_en=2'b11 exactly 1 cycle two edges later; core_base = {24'h800000, 24'h000000}.
REQ-038 NUM_CORES=4, core 2 returns rdy+valid key 24'h00A5F3 at cycle 50 -> found=1, key=24'h00A5F3, winner=2, core_abort=4'b1011 one cycle, done next cycle.
REQ-039 Cores 1 and 3 both valid same cycle -> winner=1; all cores finish with valid=0 -> found=0, no abort pulse, done=1.
REQ-040 MAX_CYCLES=100, no core finishes -> timeout=1, found=0, core_abort all ones one cycle, cycles=100-101 range fixed by model, done=1.
REQ-041 Core 0 rdy low at start -> stays WAIT_RDY, core_en=0 until rdy rises; start pulses during RUN ignored.
REQ-042 rst_n asserted in RUN -> outputs 0 same cycle; later start performs clean full search.
